// File: rtl/olivia_mc_ctrl_pkg.sv
// Shared definitions for the Olivia multi-cycle control sequencer.
// Holds the LEGv8 opcodes, FSM state encodings, instruction classes and mux encodings.
package olivia_mc_ctrl_pkg;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  // CB- and B-format opcodes are shorter than 11 bits; the rest of the field is immediate.
  localparam logic [7:0]  OP_CBZ_PFX = 8'hB4;
  localparam logic [5:0]  OP_B_PFX   = 6'h05;

  localparam logic [1:0] PC_SRC_SEQ = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;

  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_PASSB = 2'd1;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_LD      = 3'd1,
    CLS_ST      = 3'd2,
    CLS_CBZ     = 3'd3,
    CLS_B       = 3'd4,
    CLS_ILLEGAL = 3'd5
  } insn_class_t;

  function automatic logic is_mem_class(input insn_class_t c);
    return (c == CLS_LD) || (c == CLS_ST);
  endfunction

endpackage

// File: rtl/olivia_mc_ctrl_opdecode.sv
// Combinational opcode classifier: maps IR[31:21] to an instruction class.
// Shared between the multi-cycle sequencer and the single-cycle decode.
module olivia_mc_ctrl_opdecode
  import olivia_mc_ctrl_pkg::*;
#(
  parameter int OPC_W = 11
) (
  input  logic [OPC_W-1:0] opcode,
  output logic [2:0]       insn_class
);

  always_comb begin
    insn_class = CLS_ILLEGAL;
    if (opcode == OPC_W'(OP_ADD) || opcode == OPC_W'(OP_SUB) ||
        opcode == OPC_W'(OP_AND) || opcode == OPC_W'(OP_ORR)) begin
      insn_class = CLS_R;
    end else if (opcode == OPC_W'(OP_LDUR)) begin
      insn_class = CLS_LD;
    end else if (opcode == OPC_W'(OP_STUR)) begin
      insn_class = CLS_ST;
    end else if (opcode[OPC_W-1 -: 8] == OP_CBZ_PFX) begin
      insn_class = CLS_CBZ;
    end else if (opcode[OPC_W-1 -: 6] == OP_B_PFX) begin
      insn_class = CLS_B;
    end
  end

endmodule

// File: rtl/olivia_mc_ctrl.sv
// Multi-cycle control FSM for the Olivia LEGv8 core: one shared memory port,
// handshaked fetch/data access, sticky fault on illegal opcode or memory timeout.
module olivia_mc_ctrl
  import olivia_mc_ctrl_pkg::*;
#(
  parameter int OPC_W       = 11,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             ir_zero,
  input  logic             alu_zero,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg2loc,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [2:0]       state_o,
  output logic             halted,
  output logic             fault
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            state_next;
  insn_class_t       cls;
  logic [2:0]        cls_raw;
  logic [CNT_W-1:0]  wait_cnt;
  logic              timeout_hit;
  logic              fetch_hold;

  olivia_mc_ctrl_opdecode #(
    .OPC_W (OPC_W)
  ) u_opdecode (
    .opcode     (opcode),
    .insn_class (cls_raw)
  );

  assign cls         = insn_class_t'(cls_raw);
  assign timeout_hit = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  // wait_cnt is zero only in the first FETCH cycle, before any request has gone out.
  assign fetch_hold  = (state == ST_FETCH) && (wait_cnt == '0) && halt_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if ((state == ST_FETCH || state == ST_MEM) && !mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH: begin
        if (fetch_hold) begin
          state_next = ST_HALT;
        end else if (mem_ready) begin
          state_next = ST_DECODE;
        end else if (timeout_hit) begin
          state_next = ST_FAULT;
        end
      end
      ST_HALT: begin
        if (!halt_req) begin
          state_next = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (ir_zero) begin
          state_next = ST_FETCH;
        end else if (cls == CLS_ILLEGAL) begin
          state_next = ST_FAULT;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls == CLS_R) begin
          state_next = ST_WB;
        end else if (is_mem_class(cls)) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_next = (cls == CLS_LD) ? ST_WB : ST_FETCH;
        end else if (timeout_hit) begin
          state_next = ST_FAULT;
        end
      end
      ST_WB:    state_next = ST_FETCH;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_FAULT;
    endcase
  end

  // Strobes are forced low while reset is held so an in-flight request drops at once.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_SEQ;
    reg2loc      = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_OP_ADD;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    halted       = 1'b0;
    fault        = 1'b0;
    state_o      = state;
    if (rst) begin
      case (state)
        ST_FETCH: begin
          if (!fetch_hold) begin
            mem_req = 1'b1;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              pc_src   = PC_SRC_SEQ;
            end
          end
        end
        ST_DECODE: begin
          reg2loc = (cls == CLS_ST) || (cls == CLS_CBZ);
        end
        ST_EXEC: begin
          case (cls)
            CLS_R: begin
              alu_src_b = 1'b0;
              alu_op    = ALU_OP_FUNCT;
            end
            CLS_LD, CLS_ST: begin
              alu_src_b = 1'b1;
              alu_op    = ALU_OP_ADD;
            end
            CLS_CBZ: begin
              alu_op  = ALU_OP_PASSB;
              reg2loc = 1'b1;
              if (alu_zero) begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_BR;
              end
            end
            CLS_B: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_BR;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls == CLS_ST);
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (cls == CLS_LD);
        end
        ST_HALT:  halted = 1'b1;
        ST_FAULT: fault  = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
